// File: rtl/baud_rx_if.sv
// Serial receive bundle: the raw line in, the decoded byte and status pulses out.
// The receiver uses the slave view; whatever drives the line uses the master view.
interface baud_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input data, valid, frame_err, busy);
    modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/baud_rx.sv
// 8N1 UART receiver: start-bit midpoint qualification, mid-bit data sampling,
// stop-bit framing check and a break state that waits for the line to go idle.
module baud_rx #(
    parameter int CLKS_PER_BIT = 414,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       CLKIN,
    input  logic       RESET,
    baud_rx_if.slave   bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] HALF_LAST = 10'(HALF_BIT - 1);

    logic [2:0] state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        rx_meta_d   = bus.rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line that has gone high again by mid-start-bit was only a glitch.
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            BREAK: begin
                // A held-low line must not be mistaken for the next start bit.
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_baud_rx.sv
// Directed and randomized frames against a timing/byte scoreboard for baud_rx.
module tb_baud_rx;

    localparam int C   = 414;
    localparam int H   = C / 2;
    // Edges from the line falling to valid, plus one because cyc is read at the following negedge.
    localparam int LAT = 3 + H + 9 * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    baud_rx_if bus ();

    baud_rx #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
        .CLKIN (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int         vt[$];
    logic [7:0] vd[$];
    int         ft[$];
    int         both_hi = 0;
    int         silent_change = 0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            vt.push_back(cyc);
            vd.push_back(bus.data);
        end
        if (bus.frame_err === 1'b1) ft.push_back(cyc);
        if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both_hi++;
        if (!rst && bus.valid !== 1'b1 && bus.data !== prev_data) silent_change++;
        prev_data = bus.data;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        checks++;
        assert ((tol == 0) ? (obs === exp) : (obs + tol >= exp && obs <= exp + tol))
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d tol %0d", tag, obs, exp, tol);
        end
    endtask

    function automatic logic [9:0] frame(input logic [7:0] b, input logic stop_bit);
        return {stop_bit, b, 1'b0};
    endfunction

    // Drives the first n bits of a frame, C cycles each; t_fall is cyc when the start bit went low.
    task automatic drive_bits(input logic [9:0] f, input int n, output int t_fall);
        t_fall = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx = f[i];
            if (i == 0) t_fall = cyc;
            repeat (C - 1) @(negedge clk);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy === lvl) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic clear_obs();
        vt.delete();
        vd.delete();
        ft.delete();
    endtask

    initial begin
        int         t0, t1, t2, tg, tb, tr, tp;
        logic [7:0] exp_data;
        logic [9:0] f;
        logic [7:0] rb;
        logic       bad;
        int         gap;
        int         ev_t[$];
        logic [7:0] ev_d[$];
        int         ef_t[$];

        bus.rx   = 1'b1;
        exp_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", bus.data, 8'h00, 0);
        check("rst_valid", bus.valid, 1'b0, 0);
        check("rst_ferr", bus.frame_err, 1'b0, 0);
        check("rst_busy", bus.busy, 1'b0, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single byte 0x55
        clear_obs();
        drive_bits(frame(8'h55, 1'b1), 10, t0);
        repeat (20) @(negedge clk);
        check("b55_count", vt.size(), 1, 0);
        if (vt.size() > 0) begin
            check("b55_lat", vt[0] - t0, LAT, 1);
            check("b55_byte", vd[0], 8'h55, 0);
        end
        check("b55_ferr", ft.size(), 0, 0);
        check("b55_hold", bus.data, 8'h55, 0);
        exp_data = 8'h55;

        // Back-to-back 0xA3 then 0x0F
        clear_obs();
        drive_bits(frame(8'hA3, 1'b1), 10, t1);
        drive_bits(frame(8'h0F, 1'b1), 10, t2);
        repeat (20) @(negedge clk);
        check("b2b_count", vt.size(), 2, 0);
        if (vt.size() > 1) begin
            check("b2b_first", vd[0], 8'hA3, 0);
            check("b2b_second", vd[1], 8'h0F, 0);
            check("b2b_spacing", vt[1] - vt[0], 10 * C, 1);
            check("b2b_lat", vt[1] - t2, LAT, 1);
        end
        check("b2b_ferr", ft.size(), 0, 0);
        exp_data = 8'h0F;

        // 50-cycle glitch on an idle line
        clear_obs();
        @(negedge clk);
        bus.rx = 1'b0;
        tg = cyc;
        wait_busy(1'b1, 20, tb);
        check("glitch_busy_rise", tb - tg, 3, 1);
        repeat (50 - (cyc - tg)) @(negedge clk);
        bus.rx = 1'b1;
        wait_busy(1'b0, 400, tb);
        check("glitch_busy_fall", tb - tg, 3 + H, 1);
        repeat (20) @(negedge clk);
        check("glitch_valid", vt.size(), 0, 0);
        check("glitch_ferr", ft.size(), 0, 0);
        check("glitch_data", bus.data, exp_data, 0);

        // 0x81 with a low stop bit and a long break afterwards
        clear_obs();
        drive_bits(frame(8'h81, 1'b0), 10, t0);
        repeat (2001) @(negedge clk);
        check("brk_ferr_count", ft.size(), 1, 0);
        if (ft.size() > 0) check("brk_ferr_lat", ft[0] - t0, LAT, 1);
        check("brk_valid", vt.size(), 0, 0);
        check("brk_data", bus.data, exp_data, 0);
        check("brk_busy_held", bus.busy, 1'b1, 0);
        @(negedge clk);
        bus.rx = 1'b1;
        tr = cyc;
        wait_busy(1'b0, 20, tb);
        check("brk_busy_fall", tb - tr, 3, 1);
        repeat (10 * C) @(negedge clk);
        check("brk_no_spurious_v", vt.size(), 0, 0);
        check("brk_no_spurious_f", ft.size(), 1, 0);

        // Reset in the middle of data bit 4, then a clean 0x3C
        clear_obs();
        f = frame(8'hE7, 1'b1);
        drive_bits(f, 5, tp);
        @(negedge clk);
        bus.rx = f[5];
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_data", bus.data, 8'h00, 0);
        check("mrst_valid", bus.valid, 1'b0, 0);
        check("mrst_ferr", bus.frame_err, 1'b0, 0);
        check("mrst_busy", bus.busy, 1'b0, 0);
        bus.rx = 1'b1;
        exp_data = 8'h00;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (11 * C) @(negedge clk);
        check("mrst_drop_v", vt.size(), 0, 0);
        check("mrst_drop_f", ft.size(), 0, 0);
        check("mrst_idle", bus.busy, 1'b0, 0);
        drive_bits(frame(8'h3C, 1'b1), 10, t0);
        repeat (20) @(negedge clk);
        check("mrst_3c_count", vt.size(), 1, 0);
        if (vt.size() > 0) begin
            check("mrst_3c_byte", vd[0], 8'h3C, 0);
            check("mrst_3c_lat", vt[0] - t0, LAT, 1);
        end
        exp_data = 8'h3C;

        // Randomized bytes, stop bits and inter-frame gaps against a scoreboard
        clear_obs();
        for (int n = 0; n < 6; n++) begin
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            drive_bits(frame(rb, ~bad), 10, t0);
            if (bad) begin
                ef_t.push_back(t0 + LAT);
                gap = $urandom_range(3, 12);
            end else begin
                ev_t.push_back(t0 + LAT);
                ev_d.push_back(rb);
                exp_data = rb;
                gap = $urandom_range(0, 12);
            end
            repeat (gap) begin
                @(negedge clk);
                bus.rx = 1'b1;
            end
        end
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        check("rnd_valid_count", vt.size(), ev_t.size(), 0);
        check("rnd_ferr_count", ft.size(), ef_t.size(), 0);
        for (int i = 0; i < vt.size() && i < ev_t.size(); i++) begin
            check($sformatf("rnd_v%0d_byte", i), vd[i], ev_d[i], 0);
            check($sformatf("rnd_v%0d_time", i), vt[i], ev_t[i], 1);
        end
        for (int i = 0; i < ft.size() && i < ef_t.size(); i++)
            check($sformatf("rnd_f%0d_time", i), ft[i], ef_t[i], 1);
        check("rnd_final_data", bus.data, exp_data, 0);

        // Invariants collected across the whole run
        check("never_both_pulses", both_hi, 0, 0);
        check("data_only_on_valid", silent_change, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_rx.md
BAUD_RX -- requirements
Module: baud_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 414, meaning CLKIN cycles per serial bit (legal range 4..1023).
REQ-002 SHALL have parameter HALF_BIT, default CLKS_PER_BIT/2 (integer division), meaning CLKIN cycles from start-bit edge to the start-bit mid-point check.
REQ-003 SHALL have port CLKIN  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  serial line, idle high, asynchronous to CLKIN.
REQ-006 SHALL have port data  output  8  last correctly framed byte received.
REQ-007 SHALL have port valid  output  1  one-cycle pulse: data just updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-011 SHALL use 8N1 framing, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1); no parity.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK, with a 10-bit cycle counter cnt and a 3-bit bit index idx.
REQ-013 IDLE: on rx_s==0 SHALL go to START with cnt=0; otherwise SHALL remain in IDLE.
REQ-014 START: SHALL increment cnt until cnt==HALF_BIT-1, then sample rx_s; if 0, go to DATA with cnt=0 and idx=0; if 1 (glitch), return to IDLE with no output pulse.
REQ-015 DATA: SHALL increment cnt; at cnt==CLKS_PER_BIT-1 it SHALL shift rx_s into bit idx of a shift register, set cnt=0, and increment idx; after idx 7 is sampled it SHALL go to STOP.
REQ-016 STOP: at cnt==CLKS_PER_BIT-1, if rx_s==1 it SHALL load data from the shift register, pulse valid for exactly one cycle, and go to IDLE.
REQ-017 STOP: at that sample, if rx_s==0 it SHALL pulse frame_err for one cycle, leave data unchanged, and go to BREAK.
REQ-018 BREAK: SHALL remain in BREAK until rx_s==1, then go to IDLE; a low line SHALL never be taken as a new start bit.
REQ-019 data SHALL hold its value between valid pulses; valid and frame_err SHALL never be high in the same cycle.
REQ-020 The counter SHALL never exceed CLKS_PER_BIT-1; no wrap-around of cnt or idx SHALL be relied on.
REQ-021 A start edge arriving in the cycle IDLE is entered (back-to-back frames) SHALL be accepted with no dead cycle.
REQ-022 Sampling latency: valid SHALL assert 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (+/-1) after rx falls, i.e. 3935+/-1 cycles at default parameters.

Reset
REQ-023 RESET high SHALL immediately and asynchronously force state=IDLE, cnt=0, idx=0, shift register=0, data=8'h00, valid=0, frame_err=0, busy=0, and synchronizer flops=1.
REQ-024 RESET asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; after release, reception SHALL restart only on a fresh falling edge.

Verification
REQ-025 Send byte 0x55 at 414 cycles/bit -> a single valid pulse about 3935 cycles after the start edge, data=0x55, frame_err never high.
REQ-026 Send 0xA3 then 0x0F back-to-back (stop bit immediately followed by start) -> two valid pulses about 4140 cycles apart, data=0xA3 then 0x0F.
REQ-027 Drive a 50-cycle low glitch on idle rx -> return to IDLE after about 207 cycles, no valid, no frame_err, data unchanged.
REQ-028 Send 0x81 with stop bit driven 0, holding rx low 2000 more cycles -> one frame_err pulse, data unchanged, busy high until rx returns high, no spurious start.
REQ-029 Assert RESET during data bit 4 of a frame, then send 0x3C -> outputs at reset values during reset, the partial frame is dropped, then data=0x3C with one valid pulse.
